mmio_responder: RTL and testbench

- Memory-mapped I/O responder for the 16-bit pipelined CPU data bus.
- Decodes the I/O window 0xFFF0–0xFFFE and returns read data combinationally, so a load in the M stage sees it the same cycle.
- Owns the HEX, LEDR and LEDG output registers.
- Debounces KEY and SW, latches sticky key-press flags, and provides a prescaled free-running timer.

---
 rtl/mmio_bus_if.sv | 19 +
 rtl/mmio_responder.sv | 171 +++++++++++++++++
 tb/tb_mmio_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_bus_if : CPU M-stage data bus as seen by the MMIO responder   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mmio_bus_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] ADDR;
  logic [DBITS-1:0] DIN;
  logic             WE;
  logic [DBITS-1:0] DOUT;
  logic             SEL;

  modport master (output ADDR, DIN, WE, input DOUT, SEL);
  modport slave  (input ADDR, DIN, WE, output DOUT, SEL);
endinterface
`default_nettype wire

// File: rtl/mmio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_responder : I/O window FFF0-FFFE, LED/HEX regs, debounced     |
// | KEY/SW, sticky key flags, prescaled timer. Option: MMIO_TIMER_CMP_EN|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mmio_responder #(
  parameter int DBITS      = 16,
  parameter int DEB_CYCLES = 100000,
  parameter int TIMER_DIV  = 10000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  mmio_bus_if.slave        bus,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] HEX,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic             KEYINT
);

  localparam int               DW       = $clog2(DEB_CYCLES);
  localparam int               PW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TIMER_DIV - 1);
  localparam logic [DBITS-1:0] DEAD     = DBITS'(16'hDEAD);

  logic [3:0]       key_s1_q, key_s2_q, key_prev_q, key_stb_q;
  logic [3:0]       key_prev_d, key_stb_d;
  logic [9:0]       sw_s1_q, sw_s2_q, sw_prev_q, sw_db_q;
  logic [9:0]       sw_prev_d, sw_db_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [5:0]       kctrl_q, kctrl_d;
  logic             keyint_q, keyint_d;
  logic [DBITS-1:0] timer_q, timer_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [DBITS-1:0] hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;
`ifdef MMIO_TIMER_CMP_EN
  logic [DBITS-1:0] cmp_q, cmp_d;
`endif

  logic             sel, wr_en, deb_tick, timer_inc;
  logic [2:0]       reg_idx;
  logic [3:0]       key_eq, key_press;
  logic [9:0]       sw_eq;
  logic [5:0]       clr;
  logic [DBITS-1:0] rdata;
  logic             unused_addr0;

  assign sel          = &bus.ADDR[DBITS-1:4];
  assign reg_idx      = bus.ADDR[3:1];
  assign wr_en        = bus.WE & sel;
  assign unused_addr0 = bus.ADDR[0];

  always_comb begin
    deb_tick   = (deb_cnt_q == DEB_LAST);
    deb_cnt_d  = deb_tick ? '0 : deb_cnt_q + 1'b1;
    key_eq     = ~(key_s2_q ^ key_prev_q);
    sw_eq      = ~(sw_s2_q ^ sw_prev_q);
    key_prev_d = deb_tick ? key_s2_q : key_prev_q;
    sw_prev_d  = deb_tick ? sw_s2_q : sw_prev_q;
    key_stb_d  = deb_tick ? ((key_stb_q & ~key_eq) | (key_s2_q & key_eq)) : key_stb_q;
    sw_db_d    = deb_tick ? ((sw_db_q & ~sw_eq) | (sw_s2_q & sw_eq)) : sw_db_q;
    // key_stb holds raw (active-low) sense, so a press is a 1->0 transition
    key_press  = key_stb_q & ~key_stb_d;

    timer_inc = 1'b0;
    timer_d   = timer_q;
    pre_d     = pre_q + 1'b1;
    if (wr_en && reg_idx == 3'd3) begin
      timer_d = bus.DIN;
      pre_d   = '0;
    end else if (pre_q == PRE_LAST) begin
      timer_inc = 1'b1;
      timer_d   = timer_q + 1'b1;
      pre_d     = '0;
    end

    clr          = (wr_en && reg_idx == 3'd2) ? bus.DIN[5:0] : 6'd0;
    kctrl_d[3:0] = key_press | (kctrl_q[3:0] & ~clr[3:0]);
    kctrl_d[4]   = (|(key_press & kctrl_q[3:0] & ~clr[3:0])) | (kctrl_q[4] & ~clr[4]);
`ifdef MMIO_TIMER_CMP_EN
    kctrl_d[5]   = (timer_inc && timer_d == cmp_q) | (kctrl_q[5] & ~clr[5]);
    keyint_d     = (|kctrl_q[3:0]) | kctrl_q[5];
    cmp_d        = (wr_en && reg_idx == 3'd7) ? bus.DIN : cmp_q;
`else
    kctrl_d[5]   = 1'b0;
    keyint_d     = |kctrl_q[3:0];
`endif

    hex_d  = (wr_en && reg_idx == 3'd4) ? bus.DIN       : hex_q;
    ledr_d = (wr_en && reg_idx == 3'd5) ? bus.DIN[9:0]  : ledr_q;
    ledg_d = (wr_en && reg_idx == 3'd6) ? bus.DIN[7:0]  : ledg_q;
  end

  always_comb begin
    rdata = DEAD;
    if (sel) begin
      case (reg_idx)
        3'd0: begin rdata = '0; rdata[3:0] = ~key_stb_q; end
        3'd1: begin rdata = '0; rdata[9:0] = sw_db_q;    end
        3'd2: begin rdata = '0; rdata[5:0] = kctrl_q;    end
        3'd3: rdata = timer_q;
        3'd4: rdata = hex_q;
        3'd5: begin rdata = '0; rdata[9:0] = ledr_q;     end
        3'd6: begin rdata = '0; rdata[7:0] = ledg_q;     end
`ifdef MMIO_TIMER_CMP_EN
        3'd7: rdata = cmp_q;
`endif
        default: rdata = DEAD;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      key_s1_q   <= 4'hF;
      key_s2_q   <= 4'hF;
      key_prev_q <= 4'hF;
      key_stb_q  <= 4'hF;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_prev_q  <= '0;
      sw_db_q    <= '0;
      deb_cnt_q  <= '0;
      kctrl_q    <= '0;
      keyint_q   <= 1'b0;
      timer_q    <= '0;
      pre_q      <= '0;
      hex_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
`ifdef MMIO_TIMER_CMP_EN
      cmp_q      <= '0;
`endif
    end else begin
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_prev_d;
      key_stb_q  <= key_stb_d;
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      sw_prev_q  <= sw_prev_d;
      sw_db_q    <= sw_db_d;
      deb_cnt_q  <= deb_cnt_d;
      kctrl_q    <= kctrl_d;
      keyint_q   <= keyint_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
`ifdef MMIO_TIMER_CMP_EN
      cmp_q      <= cmp_d;
`endif
    end
  end

  assign bus.DOUT = rdata;
  assign bus.SEL  = sel;
  assign HEX      = hex_q;
  assign LEDR     = ledr_q;
  assign LEDG     = ledg_q;
  assign KEYINT   = keyint_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mmio_responder : directed bench, DEB_CYCLES=4, TIMER_DIV=3      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mmio_responder;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic        KEYINT;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  mmio_bus_if #(.DBITS(16)) bus ();

  mmio_responder #(.DBITS(16), .DEB_CYCLES(4), .TIMER_DIV(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus.slave), .KEY(KEY), .SW(SW),
    .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG), .KEYINT(KEYINT)
  );

  always #10 CLK = ~CLK;

  // Post-reset edge count; debounce ticks land on edges where cyc % 4 == 0
  always @(posedge CLK) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    bus.ADDR = a;
    bus.WE   = 1'b0;
    #1;
    chk(tag, bus.DOUT, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr_now(input logic [15:0] a, input logic [15:0] d);
    bus.ADDR = a;
    bus.DIN  = d;
    bus.WE   = 1'b1;
    @(negedge CLK);
    bus.WE   = 1'b0;
  endtask

  initial begin
    RESET_N  = 1'b0;
    KEY      = 4'hF;
    SW       = 10'h000;
    bus.ADDR = 16'h0000;
    bus.DIN  = 16'h0000;
    bus.WE   = 1'b0;
    step(3);
    RESET_N  = 1'b1;

    rd(16'hFFF0, 16'h0000, "kdata_rst");
    rd(16'hFFF4, 16'h0000, "kctrl_rst");
    rd(16'hFFF8, 16'h0000, "hex_rst");
    rd(16'hFFF2, 16'h0000, "sdata_rst");
    rd(16'h1234, 16'hDEAD, "unsel_dout");
    chk("unsel_sel", {15'b0, bus.SEL}, 16'h0000);
    chk("keyint_rst", {15'b0, KEYINT}, 16'h0000);

    // Bounce phased so every debounce sample sees the released level
    while (cyc % 4 != 0) step(1);
    for (int i = 0; i < 10; i++) begin
      KEY[1] = (i % 2 == 1);
      step(1);
      rd(16'hFFF0, 16'h0000, "kdata_bounce");
    end
    KEY[1] = 1'b0;
    step(9);
    rd(16'hFFF0, 16'h0000, "kdata_settling");
    step(1);
    rd(16'hFFF0, 16'h0002, "kdata_pressed");
    rd(16'hFFF4, 16'h0002, "kctrl_flag1");
    chk("keyint_lag", {15'b0, KEYINT}, 16'h0000);
    step(1);
    chk("keyint_set", {15'b0, KEYINT}, 16'h0001);

    KEY[1] = 1'b1;
    step(12);
    rd(16'hFFF0, 16'h0000, "kdata_release");
    rd(16'hFFF4, 16'h0002, "kctrl_hold");
    KEY[1] = 1'b0;
    step(12);
    rd(16'hFFF4, 16'h0012, "kctrl_ovr");
    rd(16'hFFF0, 16'h0002, "kdata_repress");

    bus.ADDR = 16'hFFF4;
    bus.DIN  = 16'h0012;
    bus.WE   = 1'b1;
    #1;
    chk("kctrl_old_during_wr", bus.DOUT, 16'h0012);
    @(negedge CLK);
    bus.WE = 1'b0;
    rd(16'hFFF4, 16'h0000, "kctrl_w1c");
    chk("keyint_stale", {15'b0, KEYINT}, 16'h0001);
    step(1);
    chk("keyint_clr", {15'b0, KEYINT}, 16'h0000);

    // KEY[0] driven at cyc%4==1 becomes stable exactly 7 edges later
    while (cyc % 4 != 1) step(1);
    KEY[0] = 1'b0;
    step(6);
    rd(16'hFFF4, 16'h0000, "kctrl_pre_coinc");
    wr_now(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0001, "kctrl_set_wins");
    step(1);
    chk("keyint_coinc", {15'b0, KEYINT}, 16'h0001);
    wr_now(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0000, "kctrl_clr0");
    KEY = 4'hF;

    SW = 10'h2A5;
    step(12);
    rd(16'hFFF2, 16'h02A5, "sdata");

    wr_now(16'hFFF6, 16'hFFFE);
    step(5);
    rd(16'hFFF6, 16'hFFFF, "timer_ffff");
    step(1);
    rd(16'hFFF6, 16'h0000, "timer_wrap");
    wr_now(16'hFFF6, 16'h0000);
    step(2);
    rd(16'hFFF6, 16'h0000, "timer_pre_coinc");
    wr_now(16'hFFF6, 16'h1234);
    rd(16'hFFF6, 16'h1234, "timer_wr_wins");
    step(1);
    wr_now(16'hFFF6, 16'h5555);
    step(2);
    rd(16'hFFF6, 16'h5555, "timer_presc_hold");
    step(1);
    rd(16'hFFF6, 16'h5556, "timer_presc_clr");

    wr_now(16'hFFF8, 16'hBEEF);
    wr_now(16'hFFFA, 16'hFFFF);
    wr_now(16'hFFFC, 16'h01A5);
    chk("hex_port", HEX, 16'hBEEF);
    chk("ledr_port", {6'b0, LEDR}, 16'h03FF);
    chk("ledg_port", {8'b0, LEDG}, 16'h00A5);
    rd(16'hFFF8, 16'hBEEF, "hex_rb");
    rd(16'hFFFA, 16'h03FF, "ledr_rb");
    rd(16'hFFFC, 16'h00A5, "ledg_rb");
    rd(16'hFFF9, 16'hBEEF, "hex_rb_odd");

    bus.ADDR = 16'h0FF8;
    bus.DIN  = 16'h0000;
    bus.WE   = 1'b1;
    #1;
    chk("unsel_sel_wr", {15'b0, bus.SEL}, 16'h0000);
    chk("unsel_dout_wr", bus.DOUT, 16'hDEAD);
    @(negedge CLK);
    bus.ADDR = 16'h0FFC;
    @(negedge CLK);
    bus.WE = 1'b0;
    chk("hex_unsel", HEX, 16'hBEEF);
    chk("ledg_unsel", {8'b0, LEDG}, 16'h00A5);

    rd(16'hFFFE, 16'hDEAD, "fffe_rd");
    wr_now(16'hFFFE, 16'h0003);
    rd(16'hFFFE, 16'hDEAD, "fffe_after_wr");
    wr_now(16'hFFF0, 16'hFFFF);
    rd(16'hFFF0, 16'h0000, "kdata_ro");
    rd(16'hFFF4, 16'h0000, "kctrl_bit5");

    SW     = 10'h155;
    KEY[2] = 1'b0;
    step(5);
    RESET_N = 1'b0;
    step(1);
    RESET_N = 1'b1;
    rd(16'hFFF2, 16'h0000, "sdata_reset");
    rd(16'hFFF0, 16'h0000, "kdata_reset");
    rd(16'hFFF4, 16'h0000, "kctrl_reset");
    rd(16'hFFF6, 16'h0000, "timer_reset");
    chk("hex_reset", HEX, 16'h0000);
    chk("ledr_reset", {6'b0, LEDR}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
